// File: rtl/rv_pkg.sv
// Shared RISC-V fetch constants: opcodes, the NOP word and the 2-bit BHT counter encodings.
package rv_pkg;
  localparam logic [6:0]  OPC_BRANCH = 7'b1100011;
  localparam logic [6:0]  OPC_JAL    = 7'b1101111;
  localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } bht_cnt_e;
endpackage

// File: rtl/branch_history_table.sv
// BHT_ENTRIES x 2-bit saturating counters: one combinational read port, one synchronous update port.
module branch_history_table
  import rv_pkg::*;
#(
  parameter int ENTRIES = 64,
  localparam int IW     = $clog2(ENTRIES)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [IW-1:0] i_rd_idx,
  output logic [1:0]    o_rd_cnt,
  input  logic          i_upd_valid,
  input  logic [IW-1:0] i_upd_idx,
  input  logic          i_upd_taken
);
  bht_cnt_e r_cnt [ENTRIES];

  // Read returns the pre-update value when read and update hit the same entry.
  assign o_rd_cnt = r_cnt[i_rd_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) r_cnt[i] <= WNT;
    end else if (i_upd_valid) begin
      if (i_upd_taken && r_cnt[i_upd_idx] != ST)
        r_cnt[i_upd_idx] <= bht_cnt_e'(r_cnt[i_upd_idx] + 2'd1);
      else if (!i_upd_taken && r_cnt[i_upd_idx] != SNT)
        r_cnt[i_upd_idx] <= bht_cnt_e'(r_cnt[i_upd_idx] - 2'd1);
    end
  end
endmodule

// File: rtl/fetch_predict.sv
// Fetch stage: registered PC, 1-cycle fetch output register, BHT/JAL next-PC prediction
// and execute-driven redirect and BHT training.
module fetch_predict
  import rv_pkg::*;
#(
  parameter int          BHT_ENTRIES = 64,
  parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  input  logic        mispredict,
  input  logic [31:0] new_pc,
  input  logic        update_valid,
  input  logic [31:0] update_pc,
  input  logic        update_taken,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic [31:0] immediate_value,
  output logic        condition_branch,
  output logic        taken,
  output logic        valid
);
  localparam int IW = $clog2(BHT_ENTRIES);

  logic [31:0] r_pc, r_instr, r_pc_out, r_imm;
  logic        r_cb, r_taken, r_valid;

  logic [6:0]  w_opc;
  logic        w_is_br, w_is_jal, w_taken;
  logic [31:0] w_imm_b, w_imm_j, w_imm, w_next_pc;
  logic [1:0]  w_bht_cnt;
  logic        w_unused;

  branch_history_table #(.ENTRIES(BHT_ENTRIES)) u_bht (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_rd_idx    (r_pc[IW+1:2]),
    .o_rd_cnt    (w_bht_cnt),
    .i_upd_valid (update_valid),
    .i_upd_idx   (update_pc[IW+1:2]),
    .i_upd_taken (update_taken)
  );

  assign w_unused = ^{update_pc[31:IW+2], update_pc[1:0]};

  assign w_opc    = imem_rdata[6:0];
  assign w_is_br  = (w_opc == OPC_BRANCH);
  assign w_is_jal = (w_opc == OPC_JAL);
  assign w_imm_b  = {{19{imem_rdata[31]}}, imem_rdata[31], imem_rdata[7],
                     imem_rdata[30:25], imem_rdata[11:8], 1'b0};
  assign w_imm_j  = {{11{imem_rdata[31]}}, imem_rdata[31], imem_rdata[19:12],
                     imem_rdata[20], imem_rdata[30:21], 1'b0};

  always_comb begin
    w_imm     = '0;
    w_taken   = 1'b0;
    w_next_pc = r_pc + 32'd4;
    if (w_is_br) begin
      w_imm   = w_imm_b;
      w_taken = w_bht_cnt[1];
      if (w_taken) w_next_pc = r_pc + w_imm_b;
    end else if (w_is_jal) begin
      w_imm     = w_imm_j;
      w_taken   = 1'b1;
      w_next_pc = r_pc + w_imm_j;
    end
  end

  // Redirect beats stall and imem_ready; the wrong-path word is simply not captured.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc     <= RESET_PC;
      r_instr  <= NOP_INSTR;
      r_pc_out <= '0;
      r_imm    <= '0;
      r_cb     <= 1'b0;
      r_taken  <= 1'b0;
      r_valid  <= 1'b0;
    end else if (mispredict) begin
      r_pc    <= new_pc;
      r_valid <= 1'b0;
    end else if (!stall) begin
      if (imem_ready) begin
        r_pc     <= w_next_pc;
        r_instr  <= imem_rdata;
        r_pc_out <= r_pc;
        r_imm    <= w_imm;
        r_cb     <= w_is_br;
        r_taken  <= w_taken;
        r_valid  <= 1'b1;
      end else begin
        r_valid <= 1'b0;
      end
    end
  end

  assign imem_addr        = r_pc;
  assign instr            = r_instr;
  assign pc               = r_pc_out;
  assign immediate_value  = r_imm;
  assign condition_branch = r_cb;
  assign taken            = r_taken;
  assign valid            = r_valid;
endmodule
